gol_grid_engine: RTL and testbench
==================================

// Module: gol_grid_engine
// PURPOSE
//  Parametrised Conway Life engine (B3/S23) holding a GRID_W x GRID_H cell array.
//  Computes one generation per step request by scanning one cell per clock.
//  Provides a cell edit port for cursor placement/erase and a registered read port for the VGA pixel scan.
//  Boundary is selectable: dead edges or toroidal wrap.
// PARAMETERS
//  GRID_W    10  grid columns (>=3)
//  GRID_H    10  grid rows (>=3)
//  XB         4  x coordinate width; 2**XB > GRID_W-1
//  YB         4  y coordinate width; 2**YB > GRID_H-1
//  CB         7  live_count width; 2**CB > GRID_W*GRID_H
//  WRAP       0  0 = cells outside grid are dead; 1 = toroidal (x=-1 -> GRID_W-1, x=GRID_W -> 0, same for y)
// PORTS
//  Clock       in   1   system clock (50 MHz)
//  Reset       in   1   asynchronous, active-high
//  step_req    in   1   request one generation; honoured only in IDLE
//  busy        out  1   high in SCAN and COMMIT
//  gen_done    out  1   one-cycle pulse in the COMMIT cycle
//  clear       in   1   synchronous wipe of grid and counters, any state
//  edit_en     in   1   write edit_val to cell (edit_x, edit_y)
//  edit_val    in   1   1 = alive, 0 = dead
//  edit_x      in   XB  edit column
//  edit_y      in   YB  edit row
//  edit_ack    out  1   one-cycle pulse: edit applied
//  rd_x        in   XB  read column
//  rd_y        in   YB  read row
//  rd_cell     out  1   state of (rd_x, rd_y) in current generation; 1-cycle latency
//  live_count  out  CB  number of live cells in current generation
//  gen_count   out  16  generations committed since reset/clear; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: all cells 0; FSM=IDLE; busy, gen_done, edit_ack, rd_cell = 0; live_count, gen_count = 0.
//  Storage: cur[] = displayed generation; nxt[] = generation under construction.
//  FSM states:
//   IDLE
//    - step_req=1 -> SCAN, scan index = 0, accumulator = 0
//   SCAN
//    - each cycle, cell i=(x + y*GRID_W): sum its 8 neighbours in cur[] per WRAP
//    - nxt[i] = (sum==3) | (sum==2 & cur[i]); accumulator += nxt[i]
//    - after i = GRID_W*GRID_H-1 -> COMMIT
//   COMMIT, 1 cycle
//    - cur <= nxt; live_count <= accumulator; gen_count++; gen_done=1 -> IDLE
//  Latency: step_req accepted at edge T; gen_done high during cycle T+GRID_W*GRID_H+1;
//    new cur[] visible on rd_cell from the read issued the cycle after COMMIT.
//  step_req while busy is ignored (not queued).
//  Edits:
//   - applied only in IDLE with edit_x<GRID_W and edit_y<GRID_H; edit_ack pulses next cycle
//   - live_count +1/-1 only if the cell value actually changes
//   - edits while busy or out of range are dropped; no ack
//  Edit + step_req in the same IDLE cycle: the edit is written at that edge and the scan uses the edited grid.
//  clear: cur, nxt, live_count, gen_count -> 0; FSM -> IDLE; aborts SCAN/COMMIT without gen_done;
//    clear has priority over edit and step_req in the same cycle.
//  Reset mid-SCAN: same as power-up reset; no gen_done.
//  Read port: rd_cell <= cur[rd_x + rd_y*GRID_W] every cycle; out-of-range coordinate returns 0.
//    cur[] is stable during SCAN, so the display never shows a partial generation.
//  Index arithmetic: unsigned, wide enough for GRID_W*GRID_H-1; no out-of-range array access in either WRAP mode.
// TESTING
//  1. 10x10, WRAP=0: set (4,5),(5,5),(6,5); step
//     -> alive exactly (5,4),(5,5),(5,6); gen_done 101 cycles after accept; live_count 3; gen_count 1
//  2. WRAP=1: glider at (1,0),(2,1),(0,2),(1,2),(2,2); 40 steps
//     -> identical pattern at original cells; live_count 5 every generation
//  3. WRAP=1: set corners (0,0),(9,0),(0,9),(9,9); step -> unchanged (wrapped block);
//     with WRAP=0 the same setup dies -> live_count 0
//  4. Issue step, then edit_en at (0,0) and a second step_req during SCAN
//     -> no edit_ack, (0,0) unchanged, only one gen_done, gen_count 1
//  5. Assert Reset (then separately clear) 30 cycles into SCAN
//     -> busy 0, all rd_cell 0, live_count 0, gen_count 0, no gen_done
//  6. Edit at (10,3) -> no ack, live_count unchanged; rd at (10,3) -> rd_cell 0;
//     re-write an already-alive cell -> ack, live_count unchanged

Source files
------------

// File: rtl/gol_grid_engine.sv
// gol_grid_engine: Conway Life (B3/S23) engine that scans one cell per clock and exposes edit and read ports
module gol_grid_engine #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int XB = 4,
  parameter int YB = 4,
  parameter int CB = 7,
  parameter int WRAP = 0
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          step_req,
  output logic          busy,
  output logic          gen_done,
  input  logic          clear,
  input  logic          edit_en,
  input  logic          edit_val,
  input  logic [XB-1:0] edit_x,
  input  logic [YB-1:0] edit_y,
  output logic          edit_ack,
  input  logic [XB-1:0] rd_x,
  input  logic [YB-1:0] rd_y,
  output logic          rd_cell,
  output logic [CB-1:0] live_count,
  output logic [15:0]   gen_count
);
  localparam int N = GRID_W * GRID_H;
  localparam int IB = $clog2(N);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_n;
  logic [N-1:0] cur, nxt;
  logic [XB-1:0] sx;
  logic [YB-1:0] sy;
  logic [IB-1:0] si, ei, ri;
  logic [CB-1:0] acc;
  logic [3:0] sum;
  logic nv, last, e_in, r_in, edit_ok;
  // Neighbour lookup; coordinates may be one step outside the grid and are wrapped or treated as dead
  function automatic logic alive(input logic [N-1:0] g, input int x, input int y);
    int xx, yy;
    logic ok;
    xx = WRAP == 0 ? x : x < 0 ? GRID_W - 1 : x >= GRID_W ? 0 : x;
    yy = WRAP == 0 ? y : y < 0 ? GRID_H - 1 : y >= GRID_H ? 0 : y;
    ok = xx >= 0 && xx < GRID_W && yy >= 0 && yy < GRID_H;
    return ok & g[IB'(ok ? yy * GRID_W + xx : 0)];
  endfunction
  always_comb begin
    sum = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) sum = sum + 4'(alive(cur, int'(sx) + dx, int'(sy) + dy));
    nv = (sum == 4'd3) | ((sum == 4'd2) & cur[si]);
    last = si == IB'(N - 1);
    e_in = int'(edit_x) < GRID_W && int'(edit_y) < GRID_H;
    ei = e_in ? IB'(int'(edit_y) * GRID_W + int'(edit_x)) : '0;
    r_in = int'(rd_x) < GRID_W && int'(rd_y) < GRID_H;
    ri = r_in ? IB'(int'(rd_y) * GRID_W + int'(rd_x)) : '0;
    edit_ok = state == IDLE && !clear && edit_en && e_in;
  end
  always_comb begin
    state_n = clear ? IDLE :
              state == IDLE ? (step_req ? SCAN : IDLE) :
              state == SCAN ? (last ? COMMIT : SCAN) : IDLE;
    busy = state != IDLE;
    gen_done = state == COMMIT && !clear;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      cur <= '0;
      nxt <= '0;
      sx <= '0;
      sy <= '0;
      si <= '0;
      acc <= '0;
      live_count <= '0;
      gen_count <= '0;
      edit_ack <= 1'b0;
    end else if (clear) begin
      cur <= '0;
      nxt <= '0;
      sx <= '0;
      sy <= '0;
      si <= '0;
      acc <= '0;
      live_count <= '0;
      gen_count <= '0;
      edit_ack <= 1'b0;
    end else begin
      edit_ack <= edit_ok;
      if (edit_ok) begin
        cur[ei] <= edit_val;
        if (cur[ei] != edit_val) live_count <= edit_val ? live_count + CB'(1) : live_count - CB'(1);
      end
      if (state == IDLE && step_req) begin
        sx <= '0;
        sy <= '0;
        si <= '0;
        acc <= '0;
      end
      if (state == SCAN) begin
        nxt[si] <= nv;
        acc <= acc + CB'(nv);
        si <= si + IB'(1);
        sx <= int'(sx) == GRID_W - 1 ? '0 : sx + XB'(1);
        sy <= int'(sx) == GRID_W - 1 ? sy + YB'(1) : sy;
      end
      if (state == COMMIT) begin
        cur <= nxt;
        live_count <= acc;
        gen_count <= gen_count + 16'd1;
      end
    end
  // cur only changes at COMMIT, so the display never sees a half-built generation
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) rd_cell <= 1'b0;
    else rd_cell <= r_in & cur[ri];
endmodule

// File: tb/tb_gol_grid_engine.sv
// tb_gol_grid_engine: directed checks of the Life engine, run side by side with dead-edge and toroidal instances
module tb_gol_grid_engine;
  logic Clock = 1'b0, Reset = 1'b1, step_req = 1'b0, clear = 1'b0, edit_en = 1'b0, edit_val = 1'b0;
  logic [3:0] edit_x = '0, edit_y = '0, rd_x = '0, rd_y = '0;
  logic [1:0] busy, gen_done, edit_ack, rd_cell;
  logic [6:0] live [2];
  logic [15:0] gen [2];
  logic [99:0] g0, g1, e;
  int passed = 0, total = 0, cyc, pulses, acks;

  always #5 Clock = ~Clock;

  gol_grid_engine #(.WRAP(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .step_req(step_req), .busy(busy[0]), .gen_done(gen_done[0]),
    .clear(clear), .edit_en(edit_en), .edit_val(edit_val), .edit_x(edit_x), .edit_y(edit_y),
    .edit_ack(edit_ack[0]), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell[0]),
    .live_count(live[0]), .gen_count(gen[0]));
  gol_grid_engine #(.WRAP(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .step_req(step_req), .busy(busy[1]), .gen_done(gen_done[1]),
    .clear(clear), .edit_en(edit_en), .edit_val(edit_val), .edit_x(edit_x), .edit_y(edit_y),
    .edit_ack(edit_ack[1]), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell[1]),
    .live_count(live[1]), .gen_count(gen[1]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic edit(input int x, input int y, input logic v, input logic [1:0] ack);
    edit_x = 4'(x);
    edit_y = 4'(y);
    edit_val = v;
    edit_en = 1'b1;
    @(negedge Clock);
    edit_en = 1'b0;
    chk("edit_ack", 128'(edit_ack), 128'(ack));
  endtask

  task automatic rd_grid();
    for (int i = 0; i < 100; i++) begin
      rd_x = 4'(i % 10);
      rd_y = 4'(i / 10);
      @(negedge Clock);
      g0[i] = rd_cell[0];
      g1[i] = rd_cell[1];
    end
  endtask

  // cyc = falling edges after the accept edge until gen_done is seen; returns one cycle after COMMIT
  task automatic step(output int c);
    step_req = 1'b1;
    @(negedge Clock);
    step_req = 1'b0;
    c = 0;
    while (gen_done[0] !== 1'b1 && c < 300) begin
      @(negedge Clock);
      c++;
    end
    chk("step_gen_done", 128'(gen_done), 128'd3);
    @(negedge Clock);
    chk("gen_done_one_cycle", 128'(gen_done), 128'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
  endtask

  task automatic watch(input int n, output int p, output int a);
    p = 0;
    a = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      p += int'(gen_done[0]) + int'(gen_done[1]);
      a += int'(edit_ack[0]) + int'(edit_ack[1]);
    end
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_gen_done", 128'(gen_done), 128'd0);
    chk("rst_edit_ack", 128'(edit_ack), 128'd0);
    chk("rst_rd_cell", 128'(rd_cell), 128'd0);
    chk("rst_live", 128'({live[1], live[0]}), 128'd0);
    chk("rst_gen", 128'({gen[1], gen[0]}), 128'd0);
    // horizontal blinker flips to vertical
    edit(4, 5, 1'b1, 2'b11);
    edit(5, 5, 1'b1, 2'b11);
    edit(6, 5, 1'b1, 2'b11);
    chk("t1_live_pre", 128'({live[1], live[0]}), 128'({7'd3, 7'd3}));
    step(cyc);
    chk("t1_latency", 128'(cyc + 1), 128'd101);
    rd_grid();
    e = '0;
    e[45] = 1'b1;
    e[55] = 1'b1;
    e[65] = 1'b1;
    chk("t1_grid_w0", 128'(g0), 128'(e));
    chk("t1_grid_w1", 128'(g1), 128'(e));
    chk("t1_live", 128'({live[1], live[0]}), 128'({7'd3, 7'd3}));
    chk("t1_gen", 128'({gen[1], gen[0]}), 128'({16'd1, 16'd1}));
    // out-of-range edit and read, redundant and real edits
    edit(10, 3, 1'b1, 2'b00);
    chk("t6_live_oor", 128'({live[1], live[0]}), 128'({7'd3, 7'd3}));
    rd_x = 4'd10;
    rd_y = 4'd3;
    @(negedge Clock);
    chk("t6_rd_oor", 128'(rd_cell), 128'd0);
    rd_x = 4'd5;
    rd_y = 4'd15;
    @(negedge Clock);
    chk("t6_rd_oor_y", 128'(rd_cell), 128'd0);
    edit(5, 5, 1'b1, 2'b11);
    chk("t6_live_rewrite", 128'({live[1], live[0]}), 128'({7'd3, 7'd3}));
    edit(5, 5, 1'b0, 2'b11);
    chk("t6_live_erase", 128'({live[1], live[0]}), 128'({7'd2, 7'd2}));
    edit(5, 5, 1'b1, 2'b11);
    chk("t6_live_restore", 128'({live[1], live[0]}), 128'({7'd3, 7'd3}));
    // asynchronous reset 30 cycles into a scan
    step_req = 1'b1;
    @(negedge Clock);
    step_req = 1'b0;
    repeat (30) @(negedge Clock);
    chk("t5_busy_pre", 128'(busy), 128'd3);
    Reset = 1'b1;
    #1;
    chk("t5_busy_async", 128'(busy), 128'd0);
    @(negedge Clock);
    Reset = 1'b0;
    chk("t5_live", 128'({live[1], live[0]}), 128'd0);
    chk("t5_gen", 128'({gen[1], gen[0]}), 128'd0);
    watch(150, pulses, acks);
    chk("t5_no_gen_done", 128'(pulses), 128'd0);
    chk("t5_busy", 128'(busy), 128'd0);
    rd_grid();
    chk("t5_grid", 128'({g1, g0}), 128'd0);
    // clear 30 cycles into the second scan
    edit(4, 5, 1'b1, 2'b11);
    edit(5, 5, 1'b1, 2'b11);
    edit(6, 5, 1'b1, 2'b11);
    step(cyc);
    chk("t5c_gen_pre", 128'({gen[1], gen[0]}), 128'({16'd1, 16'd1}));
    step_req = 1'b1;
    @(negedge Clock);
    step_req = 1'b0;
    repeat (30) @(negedge Clock);
    pulse_clear();
    chk("t5c_busy", 128'(busy), 128'd0);
    chk("t5c_live", 128'({live[1], live[0]}), 128'd0);
    chk("t5c_gen", 128'({gen[1], gen[0]}), 128'd0);
    watch(150, pulses, acks);
    chk("t5c_no_gen_done", 128'(pulses), 128'd0);
    rd_grid();
    chk("t5c_grid", 128'({g1, g0}), 128'd0);
    // four corners: a block on the torus, isolated cells with dead edges
    edit(0, 0, 1'b1, 2'b11);
    edit(9, 0, 1'b1, 2'b11);
    edit(0, 9, 1'b1, 2'b11);
    edit(9, 9, 1'b1, 2'b11);
    step(cyc);
    rd_grid();
    e = '0;
    e[0] = 1'b1;
    e[9] = 1'b1;
    e[90] = 1'b1;
    e[99] = 1'b1;
    chk("t3_grid_w1", 128'(g1), 128'(e));
    chk("t3_grid_w0", 128'(g0), 128'd0);
    chk("t3_live", 128'({live[1], live[0]}), 128'({7'd4, 7'd0}));
    // edit and second step_req during a scan are dropped
    pulse_clear();
    step_req = 1'b1;
    @(negedge Clock);
    step_req = 1'b0;
    repeat (5) @(negedge Clock);
    edit_x = 4'd0;
    edit_y = 4'd0;
    edit_val = 1'b1;
    edit_en = 1'b1;
    step_req = 1'b1;
    @(negedge Clock);
    edit_en = 1'b0;
    step_req = 1'b0;
    chk("t4_no_ack_now", 128'(edit_ack), 128'd0);
    watch(250, pulses, acks);
    chk("t4_one_gen_done", 128'(pulses), 128'd2);
    chk("t4_no_ack", 128'(acks), 128'd0);
    chk("t4_gen", 128'({gen[1], gen[0]}), 128'({16'd1, 16'd1}));
    rd_x = 4'd0;
    rd_y = 4'd0;
    @(negedge Clock);
    chk("t4_cell_00", 128'(rd_cell), 128'd0);
    // glider returns home on the 10x10 torus after 40 generations
    pulse_clear();
    edit(1, 0, 1'b1, 2'b11);
    edit(2, 1, 1'b1, 2'b11);
    edit(0, 2, 1'b1, 2'b11);
    edit(1, 2, 1'b1, 2'b11);
    edit(2, 2, 1'b1, 2'b11);
    e = '0;
    e[1] = 1'b1;
    e[12] = 1'b1;
    e[20] = 1'b1;
    e[21] = 1'b1;
    e[22] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step(cyc);
      chk("t2_live", 128'(live[1]), 128'd5);
    end
    rd_grid();
    chk("t2_grid", 128'(g1), 128'(e));
    chk("t2_gen", 128'(gen[1]), 128'd40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
